// File: rtl/pc_gen.sv
// Fetch-stage program counter: PC register, PC+4, prioritised next-PC select,
// and a small circular return-address stack for return prediction.
module pc_gen #(
  parameter int unsigned               ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0]     RESET_VECTOR = '0,
  parameter logic [ADDR_WIDTH-1:0]     EXC_VECTOR   = ADDR_WIDTH'(32'h0000_0080),
  parameter int unsigned               RAS_DEPTH    = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         stall_i,
  input  logic                         exception_i,
  input  logic                         jr_i,
  input  logic [ADDR_WIDTH-1:0]        jr_target_i,
  input  logic                         jump_i,
  input  logic [ADDR_WIDTH-1:0]        jump_target_i,
  input  logic                         branch_taken_i,
  input  logic [ADDR_WIDTH-1:0]        branch_target_i,
  input  logic                         ret_predict_i,
  input  logic                         link_push_i,
  input  logic [ADDR_WIDTH-1:0]        link_addr_i,
  output logic [ADDR_WIDTH-1:0]        pc_o,
  output logic [ADDR_WIDTH-1:0]        pc_plus4_o,
  output logic [$clog2(RAS_DEPTH):0]   ras_count_o,
  output logic                         ras_empty_o,
  output logic                         misalign_err_o,
  output logic                         ras_underflow_o
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PtrW-1:0]       top_q, top_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  misalign_q, misalign_d;
  logic                  underflow_q, underflow_d;

  logic                  ras_empty;
  logic                  push_en, pop_en;
  logic                  ras_we;
  logic [PtrW-1:0]       ras_waddr;

  assign pc_plus4_o      = pc_q + ADDR_WIDTH'(4);
  assign ras_empty       = (cnt_q == '0);
  assign pc_o            = pc_q;
  assign ras_count_o     = cnt_q;
  assign ras_empty_o     = ras_empty;
  assign misalign_err_o  = misalign_q;
  assign ras_underflow_o = underflow_q;

  always_comb begin
    pc_d        = pc_q;
    misalign_d  = 1'b0;
    underflow_d = 1'b0;
    push_en     = 1'b0;
    pop_en      = 1'b0;
    if (exception_i) begin
      pc_d = EXC_VECTOR;
    end else if (!stall_i) begin
      push_en = link_push_i;
      if (jr_i) begin
        if (jr_target_i[1:0] != 2'b00) begin
          pc_d       = EXC_VECTOR;
          misalign_d = 1'b1;
        end else begin
          pc_d = jr_target_i;
        end
      end else if (jump_i) begin
        pc_d = {jump_target_i[ADDR_WIDTH-1:2], 2'b00};
      end else if (branch_taken_i) begin
        pc_d = {branch_target_i[ADDR_WIDTH-1:2], 2'b00};
      end else if (ret_predict_i) begin
        if (ras_empty) begin
          pc_d        = pc_plus4_o;
          underflow_d = 1'b1;
        end else begin
          pc_d   = ras_q[top_q];
          pop_en = 1'b1;
        end
      end else begin
        pc_d = pc_plus4_o;
      end
    end
  end

  // Push+pop replaces the top entry in place; pointer and count stay put.
  always_comb begin
    top_d     = top_q;
    cnt_d     = cnt_q;
    ras_we    = 1'b0;
    ras_waddr = top_q + PtrW'(1);
    if (push_en && pop_en) begin
      ras_we    = 1'b1;
      ras_waddr = top_q;
    end else if (push_en) begin
      ras_we = 1'b1;
      top_d  = top_q + PtrW'(1);
      if (cnt_q != CntW'(RAS_DEPTH)) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (pop_en) begin
      top_d = top_q - PtrW'(1);
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q        <= RESET_VECTOR;
      top_q       <= '0;
      cnt_q       <= '0;
      misalign_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      top_q       <= top_d;
      cnt_q       <= cnt_d;
      misalign_q  <= misalign_d;
      underflow_q <= underflow_d;
      if (ras_we) begin
        ras_q[ras_waddr] <= link_addr_i;
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: expected state is queued when a cycle's stimulus
// is driven and compared against the DUT outputs after the following edge.
`timescale 1ns/1ps
module tb_pc_gen;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall, exception, jr, jump, branch_taken, ret_predict, link_push;
  logic [W-1:0]  jr_target, jump_target, branch_target, link_addr;
  logic [W-1:0]  pc, pc_plus4;
  logic [2:0]    ras_count;
  logic          ras_empty, misalign_err, ras_underflow;

  typedef struct packed {
    logic [W-1:0] pc;
    logic [W-1:0] pc_plus4;
    logic [2:0]   cnt;
    logic         empty;
    logic         mis;
    logic         und;
  } obs_t;

  obs_t sb[$];
  obs_t got, want;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pc_gen #(
    .ADDR_WIDTH  (32),
    .RESET_VECTOR(32'h0000_0000),
    .EXC_VECTOR  (32'h0000_0080),
    .RAS_DEPTH   (4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .stall_i        (stall),
    .exception_i    (exception),
    .jr_i           (jr),
    .jr_target_i    (jr_target),
    .jump_i         (jump),
    .jump_target_i  (jump_target),
    .branch_taken_i (branch_taken),
    .branch_target_i(branch_target),
    .ret_predict_i  (ret_predict),
    .link_push_i    (link_push),
    .link_addr_i    (link_addr),
    .pc_o           (pc),
    .pc_plus4_o     (pc_plus4),
    .ras_count_o    (ras_count),
    .ras_empty_o    (ras_empty),
    .misalign_err_o (misalign_err),
    .ras_underflow_o(ras_underflow)
  );

  function automatic obs_t mk(input logic [W-1:0] p, input int c, input logic m, input logic u);
    obs_t e;
    e.pc       = p;
    e.pc_plus4 = p + 32'd4;
    e.cnt      = 3'(c);
    e.empty    = (c == 0);
    e.mis      = m;
    e.und      = u;
    return e;
  endfunction

  function automatic obs_t sample();
    return {pc, pc_plus4, ras_count, ras_empty, misalign_err, ras_underflow};
  endfunction

  task automatic idle();
    rst_n = 1'b1; stall = 1'b0; exception = 1'b0; jr = 1'b0; jump = 1'b0;
    branch_taken = 1'b0; ret_predict = 1'b0; link_push = 1'b0;
    jr_target = '0; jump_target = '0; branch_target = '0; link_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [W-1:0] exp_pc [5] = '{32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 5; i++) begin
      idle();
      rst_n = (i >= 2);
      sb.push_back(mk(exp_pc[i], 0, 1'b0, 1'b0));
      step();
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset[%0d]: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_priority();
    logic [W-1:0] exp_pc [4] = '{32'h80, 32'h400, 32'h800, 32'h100};
    for (int i = 0; i < 4; i++) begin
      idle();
      exception     = (i == 0);
      jr            = (i <= 1);
      jr_target     = 32'h400;
      jump          = (i <= 2);
      jump_target   = 32'h803;
      branch_taken  = 1'b1;
      branch_target = 32'h101;
      sb.push_back(mk(exp_pc[i], 0, 1'b0, 1'b0));
      step();
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL priority[%0d]: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) begin
      idle();
      stall         = 1'b1;
      exception     = (i == 3);
      branch_taken  = 1'b1;
      branch_target = 32'h200;
      link_push     = 1'b1;
      link_addr     = 32'h55;
      sb.push_back(mk((i == 3) ? 32'h80 : 32'h100, 0, 1'b0, 1'b0));
      step();
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL stall[%0d]: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_misalign();
    logic [W-1:0] exp_pc [3] = '{32'h80, 32'h84, 32'h400};
    for (int i = 0; i < 3; i++) begin
      idle();
      jr        = (i != 1);
      jr_target = (i == 0) ? 32'h402 : 32'h400;
      sb.push_back(mk(exp_pc[i], 0, (i == 0), 1'b0));
      step();
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL misalign[%0d]: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_ras();
    // Five pushes into a 4-deep stack, four pops, then one underflowing pop.
    logic [W-1:0] exp_pc [11] = '{32'h404, 32'h408, 32'h40C, 32'h410, 32'h414,
                                  32'h50, 32'h40, 32'h30, 32'h20, 32'h24, 32'h28};
    int           exp_cnt [11] = '{1, 2, 3, 4, 4, 3, 2, 1, 0, 0, 0};
    for (int i = 0; i < 11; i++) begin
      idle();
      link_push   = (i < 5);
      link_addr   = 32'(16 * (i + 1));
      ret_predict = (i >= 5) && (i < 10);
      sb.push_back(mk(exp_pc[i], exp_cnt[i], 1'b0, (i == 9)));
      step();
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL ras[%0d]: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_pc [5] = '{32'h2C, 32'h30, 32'h20, 32'h99, 32'h10};
    int           exp_cnt [5] = '{1, 2, 2, 1, 0};
    logic [W-1:0] lk [5] = '{32'h10, 32'h20, 32'h99, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      idle();
      link_push   = (i <= 2);
      link_addr   = lk[i];
      ret_predict = (i >= 2);
      sb.push_back(mk(exp_pc[i], exp_cnt[i], 1'b0, 1'b0));
      step();
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_wrap();
    // Push alongside a jump, wrap past the top of the address space, then return.
    logic [W-1:0] exp_pc [3] = '{32'hFFFF_FFFC, 32'h0, 32'h77};
    int           exp_cnt [3] = '{1, 1, 0};
    for (int i = 0; i < 3; i++) begin
      idle();
      jump        = (i == 0);
      jump_target = 32'hFFFF_FFFE;
      link_push   = (i == 0);
      link_addr   = 32'h77;
      ret_predict = (i == 2);
      sb.push_back(mk(exp_pc[i], exp_cnt[i], 1'b0, 1'b0));
      step();
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL wrap[%0d]: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      idle();
      rst_n        = (i == 0);
      link_push    = 1'b1;
      link_addr    = 32'hAA;
      stall        = (i == 1);
      exception    = (i == 1);
      branch_taken = 1'b1;
      branch_target = 32'h300;
      sb.push_back((i == 0) ? mk(32'h300, 1, 1'b0, 1'b0) : mk(32'h0, 0, 1'b0, 1'b0));
      step();
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got %h want %h", i, got, want);
      end
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_priority();
    test_stall();
    test_misalign();
    test_ras();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter unit for the instruction-fetch stage: holds the fetch PC register and computes PC+4. Each cycle it selects the next PC from sequential, branch, jump, jump-register, return-prediction and exception sources by fixed priority. A small return-address stack (RAS) predicts subroutine returns, and misaligned register jumps are trapped. It replaces the combinational PC mux/adder pair and adds the PC register itself, stall, flush and prediction.

## Interface
- ADDR_WIDTH, 32: PC width in bits (≥ 8).
- RESET_VECTOR, 0x0000_0000: PC value loaded by reset.
- EXC_VECTOR, 0x0000_0080: PC value loaded on exception or misaligned jump.
- RAS_DEPTH, 4: return-stack entries (power of two, ≥ 2).

- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  synchronous, active-low reset
- stall  in  1  hold PC and RAS this cycle
- exception  in  1  redirect to EXC_VECTOR (overrides stall)
- jr  in  1  jump-register redirect
- jr_target  in  ADDR_WIDTH  jump-register target
- jump  in  1  absolute jump redirect
- jump_target  in  ADDR_WIDTH  jump target
- branch_taken  in  1  taken-branch redirect
- branch_target  in  ADDR_WIDTH  branch target
- ret_predict  in  1  predict a return: next PC = RAS top, pop
- link_push  in  1  push link_addr onto RAS (JAL/JALR seen)
- link_addr  in  ADDR_WIDTH  return address to push
- pc  out  ADDR_WIDTH  current fetch address (registered)
- pc_plus4  out  ADDR_WIDTH  pc + 4 (combinational)
- ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries
- ras_empty  out  1  ras_count == 0
- misalign_err  out  1  registered one-cycle pulse: jr_target[1:0] ≠ 0
- ras_underflow  out  1  registered one-cycle pulse: ret_predict with empty RAS

## Operation
- Next-PC priority, highest first:
  - exception → EXC_VECTOR
  - jr → jr_target; if jr_target[1:0] ≠ 0, EXC_VECTOR instead and misalign_err = 1 next cycle
  - jump → jump_target
  - branch_taken → branch_target
  - ret_predict → RAS top, or pc_plus4 if empty, with ras_underflow = 1 next cycle
  - otherwise → pc_plus4
- branch_target and jump_target are loaded with bits [1:0] forced to 0.
- stall = 1 and exception = 0: pc, RAS and error flags hold (flags clear to 0). All other inputs are ignored.
- exception = 1: PC loads EXC_VECTOR regardless of stall. RAS is untouched and push/pop are suppressed.
- RAS is a circular buffer with a top pointer. Pop applies only when ret_predict is the selected source; pop on empty changes nothing.
- Push: write link_addr at top+1 and advance the pointer. ras_count saturates at RAS_DEPTH; push on full overwrites the oldest entry.
- Simultaneous pop and push: the top entry is replaced by link_addr and ras_count is unchanged. The next PC uses the old top. If empty, only the push occurs.
- push with a higher-priority redirect (jr/jump/branch): push still occurs.
- Arithmetic: pc_plus4 = pc + 4 modulo 2^ADDR_WIDTH. Wrap from all-ones-minus-3 to 0 is silent.

## Timing
- Reset (rst_n low at a rising edge): pc = RESET_VECTOR, ras_count = 0, ras_empty = 1, misalign_err = 0, ras_underflow = 0. RAS entry contents are don't-care.
- Reset has priority over every other input, including mid-redirect or mid-stall.
- Redirect latency: a source asserted in cycle N appears on pc in cycle N+1. No bubbles are inserted by this block.
- pc_plus4 follows pc combinationally in the same cycle.
- Error pulses are asserted in cycle N+1 for exactly one cycle, aligned with the faulting pc update.
- ras_count/ras_empty reflect the state after the edge. There is no combinational path from ret_predict to ras_count.
- The only combinational input-to-output path is none beyond pc → pc_plus4.

## Test plan
- Reset then free-run: rst_n low 2 cycles, release → pc = 0x0, 0x4, 0x8, 0xC on successive cycles; ras_empty = 1.
- Priority: exception, jr (0x400), jump (0x800) and branch (0x100) all in one cycle → pc = 0x80. Drop exception → pc = 0x400.
- Stall: stall = 1 for 3 cycles with branch_taken = 1 → pc holds. Stall with exception → pc = 0x80 next cycle.
- Misaligned jr: jr_target = 0x402 → pc = 0x80 and misalign_err high exactly one cycle.
- RAS with RAS_DEPTH = 4: push 0x10, 0x20, 0x30, 0x40, 0x50 → ras_count = 4. Four ret_predicts → pc = 0x50, 0x40, 0x30, 0x20. A fifth → pc = previous pc + 4 and ras_underflow pulses.
- Simultaneous push 0x99 and pop with top 0x20 → next pc = 0x20, ras_count unchanged. Next pop → pc = 0x99.
